wb_irq_ctrl: RTL and testbench
==============================

// Module: wb_irq_ctrl
// PURPOSE
//  Parametrised Wishbone interrupt controller replacing the hard-wired 32-bit interrupt vector feeding
//  the CPU. Synchronises NUM_IRQ asynchronous sources, applies per-channel polarity, edge/level mode
//  and enable mask, latches pending state, and drives one registered irq_o plus a priority vector.
//  Sits on the bus matrix as a classic single-beat Wishbone slave.
// PARAMETERS
//  NUM_IRQ      32  number of interrupt channels, 1..32; register bits >= NUM_IRQ read 0, writes ignored
//  SYNC_STAGES  2   input synchroniser depth, 2..4
//  MODE_RST     0   reset value of MODE register (bit=1 edge, 0 level)
// PORTS
//  clk_i       in   1        system clock
//  nrst_i      in   1        asynchronous active-low reset
//  wb_adr_i    in   5        byte address; [4:2] selects register, [1:0] ignored
//  wb_dat_i    in   32       write data
//  wb_sel_i    in   4        byte selects
//  wb_we_i     in   1        write enable
//  wb_cyc_i    in   1        cycle valid
//  wb_stb_i    in   1        strobe
//  wb_dat_o    out  32       read data
//  wb_ack_o    out  1        transfer acknowledge
//  wb_err_o    out  1        transfer error
//  wb_rty_o    out  1        tied 0
//  irq_src_i   in   NUM_IRQ  raw interrupt sources, asynchronous
//  irq_o       out  1        combined interrupt request to CPU, registered
// BEHAVIOUR
//  Reset (async, nrst_i=0): all outputs 0; sync chain, PENDING, ENABLE, POLARITY = 0; MODE = MODE_RST.
//  Registers (wb_adr_i[4:2]):
//   0 STATUS  RO  synchronised, polarity-corrected source level
//   1 MODE    RW  1=edge, 0=level
//   2 POLAR   RW  1=active-low/falling, 0=active-high/rising
//   3 ENABLE  RW  mask, 1=enabled
//   4 PENDING RW1C edge channels cleared by writing 1; level channels ignore writes
//   5 ACTIVE  RO  PENDING & ENABLE
//   6 VECTOR  RO  bit31=|ACTIVE, [4:0]=index of lowest-numbered ACTIVE bit, else 0
//   7 SWSET   WO  writing 1 sets PENDING of edge channels; reads 0
//  Wishbone: ack or err asserted exactly one cycle after cyc&stb sampled high, for one cycle; no ack in
//   the cycle following an ack (min 2 cycles/transfer). Read data valid with ack, reflects state at request.
//  Write with wb_sel_i != 4'hF -> err_o instead of ack, no state change. Write to RO reg -> ack, ignored.
//  Source path: cond = sync(irq_src_i) ^ POLAR. Level: PENDING[i] = cond[i] every cycle.
//   Edge: PENDING[i] set on cond 0->1 (previous-cond register), held until W1C.
//  Simultaneous edge/SWSET and W1C on same channel same cycle: set wins, PENDING stays 1.
//  MODE change level->edge: PENDING keeps current value; edge detector uses stored previous cond (no false edge).
//  POLAR write may create an edge on cond; it is treated as a real edge (documented, software masks first).
//  Latency: irq_src_i change -> STATUS/PENDING after SYNC_STAGES+1 clocks; irq_o = |ACTIVE one clock later.
//  Disabled channels still latch PENDING; enabling a pending channel raises irq_o next cycle.
//  Reset mid-transfer: ack/err drop immediately; master must re-issue.
// TESTING
//  1 Reset: nrst_i low mid-run -> all regs read 0 (MODE=MODE_RST), irq_o=0, no spurious ack.
//  2 Edge: MODE=1,ENABLE=1 ch3, pulse src[3] 1 clk -> PENDING=0x8 at SYNC_STAGES+1, irq_o 1 clk later; write PENDING=0x8 -> 0, irq_o drops.
//  3 Level: MODE=0,ENABLE=ch5, hold src[5]=1 -> PENDING bit5 set; write W1C -> stays 1; release -> 0.
//  4 Priority: ACTIVE=0x00A0 -> VECTOR=0x80000005; all clear -> VECTOR=0.
//  5 Collision: edge on ch0 same cycle as W1C of ch0 -> PENDING[0]=1; SWSET 0x2 on edge ch1 -> PENDING[1]=1.
//  6 Bus: write sel=4'h3 -> err_o 1 clk, no update; back-to-back stb -> ack every 2nd cycle; POLAR=1 ch2 with src low -> STATUS[2]=1.

Source files
------------

// File: rtl/wb_irq_ctrl.sv
// rtl/wb_irq_ctrl.sv - Wishbone interrupt controller: source sync, polarity, edge/level pending, mask, priority vector
module wb_irq_ctrl #(
  parameter int          NUM_IRQ     = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MODE_RST    = 32'h0
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic [4:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  output logic               irq_o
);

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_MODE    = 3'd1;
  localparam logic [2:0] REG_POLAR   = 3'd2;
  localparam logic [2:0] REG_ENABLE  = 3'd3;
  localparam logic [2:0] REG_PENDING = 3'd4;
  localparam logic [2:0] REG_ACTIVE  = 3'd5;
  localparam logic [2:0] REG_VECTOR  = 3'd6;
  localparam logic [2:0] REG_SWSET   = 3'd7;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] cond_q;
  logic [NUM_IRQ-1:0] mode_q;
  logic [NUM_IRQ-1:0] polar_q;
  logic [NUM_IRQ-1:0] enable_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] cond_next;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] wr_bits;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] swset;
  logic [2:0]         reg_sel;
  logic               req;
  logic               bad_sel;
  logic               wr_ok;
  logic [4:0]         vec_idx;
  logic [31:0]        rd_data;
  logic               unused_ok;

  assign wb_rty_o  = 1'b0;
  assign unused_ok = ^{wb_adr_i[1:0], wb_dat_i};

  // A new request is accepted only when no ack/err is showing, giving >= 2 cycles per transfer
  assign reg_sel = wb_adr_i[4:2];
  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign bad_sel = wb_we_i & (wb_sel_i != 4'hF);
  assign wr_ok   = req & wb_we_i & ~bad_sel;
  assign wr_bits = wb_dat_i[NUM_IRQ-1:0];

  assign active    = pending_q & enable_q;
  assign cond_next = sync_q[SYNC_STAGES-1] ^ polar_q;
  assign w1c       = (wr_ok && reg_sel == REG_PENDING) ? wr_bits : '0;
  assign swset     = (wr_ok && reg_sel == REG_SWSET)   ? wr_bits : '0;

  // Edge channels: set (hardware edge or software) overrides a same-cycle W1C
  assign pending_next = (~mode_q & cond_next)
                      | (mode_q & ((cond_next & ~cond_q) | swset | (pending_q & ~w1c)));

  always_comb begin
    vec_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 5'(i);
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_STATUS:  rd_data = 32'(cond_q);
      REG_MODE:    rd_data = 32'(mode_q);
      REG_POLAR:   rd_data = 32'(polar_q);
      REG_ENABLE:  rd_data = 32'(enable_q);
      REG_PENDING: rd_data = 32'(pending_q);
      REG_ACTIVE:  rd_data = 32'(active);
      REG_VECTOR:  rd_data = {|active, 26'd0, vec_idx};
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      cond_q    <= '0;
      pending_q <= '0;
      irq_o     <= 1'b0;
    end else begin
      sync_q[0] <= irq_src_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      cond_q    <= cond_next;
      pending_q <= pending_next;
      irq_o     <= |active;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      mode_q   <= MODE_RST[NUM_IRQ-1:0];
      polar_q  <= '0;
      enable_q <= '0;
    end else if (wr_ok) begin
      case (reg_sel)
        REG_MODE:   mode_q   <= wr_bits;
        REG_POLAR:  polar_q  <= wr_bits;
        REG_ENABLE: enable_q <= wr_bits;
        default:    ;
      endcase
    end
  end

  // Read data is captured at the request edge, so it reflects state at request time
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req & ~bad_sel;
      wb_err_o <= req & bad_sel;
      wb_dat_o <= (req & ~wb_we_i) ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// tb/tb_wb_irq_ctrl.sv - directed and randomized checks of wb_irq_ctrl against a behavioural model
`timescale 1ns/1ps
module tb_wb_irq_ctrl;

  localparam int          N    = 32;
  localparam int          S    = 3;
  localparam logic [31:0] MRST = 32'h8000_0001;

  localparam logic [4:0] A_STATUS  = 5'h00;
  localparam logic [4:0] A_MODE    = 5'h04;
  localparam logic [4:0] A_POLAR   = 5'h08;
  localparam logic [4:0] A_ENABLE  = 5'h0C;
  localparam logic [4:0] A_PENDING = 5'h10;
  localparam logic [4:0] A_ACTIVE  = 5'h14;
  localparam logic [4:0] A_VECTOR  = 5'h18;
  localparam logic [4:0] A_SWSET   = 5'h1C;

  logic        clk;
  logic        nrst;
  logic [4:0]  adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] rdat;
  logic        ack;
  logic        err;
  logic        rty;
  logic [N-1:0] src;
  logic        irq;

  wb_irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(S), .MODE_RST(MRST)) dut (
    .clk_i(clk), .nrst_i(nrst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(rdat), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty), .irq_src_i(src), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: what the outputs must show after the next rising edge
  logic [31:0] m_mode, m_polar, m_en, m_pend, m_cond, m_rdata;
  logic        m_ack, m_err, m_irq, m_rd;
  logic [31:0] hist [S];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] vector_of(input logic [31:0] a);
    for (int i = 0; i < 32; i++) if (a[i]) return {1'b1, 26'd0, 5'(i)};
    return 32'h0;
  endfunction

  function automatic logic [31:0] reg_value(input int idx);
    case (idx)
      0: return m_cond;
      1: return m_mode;
      2: return m_polar;
      3: return m_en;
      4: return m_pend;
      5: return m_pend & m_en;
      6: return vector_of(m_pend & m_en);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = MRST; m_polar = 0; m_en = 0; m_pend = 0; m_cond = 0; m_rdata = 0;
    m_ack = 0; m_err = 0; m_irq = 0; m_rd = 0;
    for (int k = 0; k < S; k++) hist[k] = 0;
  endtask

  // Source seen by the pending logic at an edge is the raw input sampled S edges earlier
  task automatic model_advance();
    logic [31:0] cond_new, w1c, sw, nxt, n_mode, n_polar, n_en;
    logic req, bad;
    int idx;
    if (!nrst) begin
      model_reset();
      return;
    end
    cond_new = hist[S-1] ^ m_polar;
    req = cyc && stb && !m_ack && !m_err;
    bad = we && (sel != 4'hF);
    idx = int'(adr[4:2]);
    w1c = 0; sw = 0; n_mode = m_mode; n_polar = m_polar; n_en = m_en;
    m_rd = req && !we;
    m_rdata = m_rd ? reg_value(idx) : 32'h0;
    if (req && we && !bad) begin
      case (idx)
        1: n_mode = wdat;
        2: n_polar = wdat;
        3: n_en = wdat;
        4: w1c = wdat;
        7: sw = wdat;
        default: ;
      endcase
    end
    for (int i = 0; i < 32; i++) begin
      if (!m_mode[i]) nxt[i] = cond_new[i];
      else if ((cond_new[i] && !m_cond[i]) || sw[i]) nxt[i] = 1'b1;
      else nxt[i] = m_pend[i] && !w1c[i];
    end
    m_irq = (m_pend & m_en) != 0;
    m_ack = req && !bad;
    m_err = req && bad;
    m_cond = cond_new; m_pend = nxt; m_mode = n_mode; m_polar = n_polar; m_en = n_en;
    for (int k = S - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = src;
  endtask

  task automatic compare();
    check("ack", 32'(ack), 32'(m_ack));
    check("err", 32'(err), 32'(m_err));
    check("rty", 32'(rty), 32'h0);
    check("irq", 32'(irq), 32'(m_irq));
    if (m_ack && m_rd) check("rdata", rdat, m_rdata);
  endtask

  task automatic step();
    model_advance();
    @(negedge clk);
    compare();
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic k, output logic e);
    cyc = 1; stb = 1; we = 1; adr = a; wdat = d; sel = s;
    step();
    k = ack; e = err;
    cyc = 0; stb = 0; we = 0; sel = 4'hF;
    step();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic k, e;
    wb_write(a, d, 4'hF, k, e);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cyc = 1; stb = 1; we = 0; adr = a; sel = 4'hF;
    step();
    d = rdat;
    cyc = 0; stb = 0;
    step();
  endtask

  task automatic check_reset_regs(input string tag);
    logic [31:0] d;
    for (int r = 0; r < 8; r++) begin
      rd(5'(r * 4), d);
      check($sformatf("%s_reg%0d", tag, r), d, (r == 1) ? MRST : 32'h0);
    end
    check($sformatf("%s_irq", tag), 32'(irq), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        k, e;
    logic [5:0]  pat;
    nrst = 0; cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 4'hF; src = '0;
    model_reset();
    repeat (3) @(negedge clk);
    nrst = 1;
    step();

    check_reset_regs("reset0");

    // Edge channel 3: one-clock pulse
    wr(A_MODE, 32'h8); wr(A_ENABLE, 32'h8);
    src[3] = 1'b1; step(); src[3] = 1'b0;
    repeat (S) step();
    check("edge_irq_early", 32'(irq), 32'h0);
    cyc = 1; stb = 1; we = 0; adr = A_PENDING;
    step();
    check("edge_irq_set", 32'(irq), 32'h1);
    check("edge_pending", rdat, 32'h8);
    cyc = 0; stb = 0; step();
    wr(A_PENDING, 32'h8);
    check("edge_irq_drop", 32'(irq), 32'h0);
    rd(A_PENDING, d); check("edge_cleared", d, 32'h0);

    // Level channel 5
    wr(A_MODE, 32'h0); wr(A_ENABLE, 32'h20);
    src[5] = 1'b1; repeat (S + 2) step();
    rd(A_PENDING, d); check("level_pending", d, 32'h20);
    check("level_irq", 32'(irq), 32'h1);
    wr(A_PENDING, 32'h20);
    rd(A_PENDING, d); check("level_w1c_ignored", d, 32'h20);
    src[5] = 1'b0; repeat (S + 2) step();
    rd(A_PENDING, d); check("level_release", d, 32'h0);

    // Priority
    wr(A_ENABLE, 32'hFF);
    src = 32'hA0; repeat (S + 2) step();
    rd(A_ACTIVE, d); check("prio_active", d, 32'hA0);
    rd(A_VECTOR, d); check("prio_vector", d, 32'h8000_0005);
    src = '0; repeat (S + 2) step();
    rd(A_VECTOR, d); check("prio_vector_clear", d, 32'h0);

    // Collision: hardware edge on ch0 at the same edge as its W1C
    wr(A_MODE, 32'h3);
    wr(A_SWSET, 32'h1);
    rd(A_PENDING, d); check("swset_ch0", d, 32'h1);
    src[0] = 1'b1; repeat (S) step();
    wr(A_PENDING, 32'h1);
    rd(A_PENDING, d); check("collision_ch0", d, 32'h1);
    wr(A_SWSET, 32'h2);
    rd(A_PENDING, d); check("swset_ch1", d, 32'h3);
    src[0] = 1'b0; repeat (S + 2) step();
    wr(A_PENDING, 32'h3);
    rd(A_PENDING, d); check("w1c_both", d, 32'h0);

    // Bus behaviour
    wb_write(A_ENABLE, 32'h1234, 4'h3, k, e);
    check("partial_err", 32'(e), 32'h1);
    check("partial_noack", 32'(k), 32'h0);
    rd(A_ENABLE, d); check("partial_nochange", d, 32'hFF);
    cyc = 1; stb = 1; we = 0; adr = A_STATUS; pat = '0;
    for (int j = 0; j < 6; j++) begin
      step();
      pat[j] = ack;
    end
    cyc = 0; stb = 0; step();
    check("b2b_ack_pattern", 32'(pat), 32'h15);
    wr(A_POLAR, 32'h4);
    repeat (S + 2) step();
    rd(A_STATUS, d); check("polar_status", d, 32'h4);
    wr(A_STATUS, 32'hFFFF_FFFF);
    rd(A_STATUS, d); check("ro_write_ignored", d, 32'h4);
    wr(A_POLAR, 32'h0);

    // Reset in the middle of a transfer
    cyc = 1; stb = 1; we = 0; adr = A_MODE;
    step();
    check("pre_reset_ack", 32'(ack), 32'h1);
    nrst = 0; cyc = 0; stb = 0;
    #1;
    check("reset_ack_drop", 32'(ack), 32'h0);
    check("reset_irq_drop", 32'(irq), 32'h0);
    step(); step();
    nrst = 1;
    step();
    check_reset_regs("reset1");

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      nrst = ($urandom_range(0, 599) != 0);
      cyc  = ($urandom_range(0, 3) != 0);
      stb  = cyc && ($urandom_range(0, 3) != 0);
      we   = 1'($urandom_range(0, 1));
      adr  = 5'($urandom);
      wdat = $urandom & ($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0000_00FF);
      sel  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 15) == 0) src[b] = ~src[b];
      step();
    end
    nrst = 1; cyc = 0; stb = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
